// File: rtl/co_cic_decimator.sv
// co_cic_decimator: N-stage I/Q CIC decimator with a runtime power-of-two rate.
// The R^N gain is normalised exactly back to DSZ bits by an arithmetic shift.
module co_cic_decimator #(
    parameter int DSZ = 16,
    parameter int N = 4,
    parameter int RLOG_MAX = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic [2:0]            dec_log2,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q,
    output logic                  out_valid
);
    localparam int W = DSZ + N * RLOG_MAX;
    logic [2:0] rate_reg, rate_next;
    logic [RLOG_MAX-1:0] cnt, last;
    logic strobe;
    logic signed [DSZ-1:0] din [2];
    logic signed [W-1:0] acc [2][1:N];
    logic signed [W-1:0] c [2][N+1];
    logic signed [W-1:0] dly [2][1:N];
    logic [N:0] v;
    logic [2:0] sh [N+1];
    always_comb begin
        din[0] = in_i;
        din[1] = in_q;
        rate_next = dec_log2 == 3'd0 ? 3'd1 : dec_log2 > 3'(RLOG_MAX) ? 3'(RLOG_MAX) : dec_log2;
        last = RLOG_MAX'((1 << rate_reg) - 1);
        strobe = cnt == last;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            rate_reg <= rate_next;
        end else begin
            cnt <= strobe ? '0 : cnt + RLOG_MAX'(1);
            if (strobe) rate_reg <= rate_next;
        end
    end
    // integrators run at full rate and wrap freely; the combs cancel the wrap
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) acc[p][1] <= '0;
            else acc[p][1] <= acc[p][1] + W'(din[p]);
            for (int k = 2; k <= N; k++) begin
                if (reset) acc[p][k] <= '0;
                else acc[p][k] <= acc[p][k] + acc[p][k-1];
            end
        end
    end
    // comb chain: each sample carries the rate it was strobed with, for the final shift
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            out_valid <= 1'b0;
            out_i <= '0;
            out_q <= '0;
            for (int k = 0; k <= N; k++) sh[k] <= '0;
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k <= N; k++) c[p][k] <= '0;
                for (int k = 1; k <= N; k++) dly[p][k] <= '0;
            end
        end else begin
            v <= {v[N-1:0], strobe};
            out_valid <= v[N];
            if (strobe) begin
                sh[0] <= rate_reg;
                c[0][0] <= acc[0][N];
                c[1][0] <= acc[1][N];
            end
            for (int k = 1; k <= N; k++) begin
                if (v[k-1]) begin
                    sh[k] <= sh[k-1];
                    for (int p = 0; p < 2; p++) begin
                        c[p][k] <= c[p][k-1] - dly[p][k];
                        dly[p][k] <= c[p][k-1];
                    end
                end
            end
            if (v[N]) begin
                out_i <= DSZ'(c[0][N] >>> (32'(sh[N]) * N));
                out_q <= DSZ'(c[1][N] >>> (32'(sh[N]) * N));
            end
        end
    end
endmodule

// File: tb/tb_co_cic_decimator.sv
// tb_co_cic_decimator: directed checks of period, latency, gain, impulse response,
// rate change, rate clamping and mid-stream reset.
module tb_co_cic_decimator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] in_q = '0;
    logic [2:0] dec_log2 = 3'd3;
    logic signed [15:0] out_i, out_q;
    logic out_valid;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rel = 0;
    int vc[$];
    int vi[$];
    int vq[$];

    co_cic_decimator dut (
        .clk(clk), .reset(reset), .in_i(in_i), .in_q(in_q), .dec_log2(dec_log2),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (out_valid) begin
            vc.push_back(cyc);
            vi.push_back(int'(out_i));
            vq.push_back(int'(out_q));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [2:0] d);
        @(negedge clk);
        dec_log2 = d;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        vc.delete();
        vi.delete();
        vq.delete();
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset(3'd3);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        total++; if (out_i !== 16'sd0) begin bad++; $display("FAIL reset_out_i: got %0d want 0", out_i); end
        total++; if (out_q !== 16'sd0) begin bad++; $display("FAIL reset_out_q: got %0d want 0", out_q); end
    endtask

    task automatic test_dc;
        in_i = 16'sd1000;
        in_q = -16'sd1000;
        do_reset(3'd3);
        run(104);
        total++; if (vc.size() != 12) begin bad++; $display("FAIL dc_count: got %0d want 12", vc.size()); end
        if (vc.size() > 0) begin
            total++; if (vi[0] !== 8) begin bad++; $display("FAIL dc_fill_i: got %0d want 8", vi[0]); end
            total++; if (vq[0] !== -9) begin bad++; $display("FAIL dc_fill_q: got %0d want -9", vq[0]); end
        end
        for (int k = 0; k < 12 && k < vc.size(); k++) begin
            total++; if (vc[k] !== rel + 13 + 8 * k) begin bad++; $display("FAIL dc_time[%0d]: got %0d want %0d", k, vc[k] - rel, 13 + 8 * k); end
            if (k >= 4) begin
                total++; if (vi[k] !== 1000) begin bad++; $display("FAIL dc_i[%0d]: got %0d want 1000", k, vi[k]); end
                total++; if (vq[k] !== -1000) begin bad++; $display("FAIL dc_q[%0d]: got %0d want -1000", k, vq[k]); end
            end
        end
    endtask

    task automatic test_fullscale;
        int nerr;
        in_i = -16'sd32768;
        in_q = 16'sd32767;
        do_reset(3'd6);
        run(20000);
        nerr = 0;
        for (int k = 4; k < vc.size(); k++) if (vi[k] != -32768 || vq[k] != 32767) nerr++;
        total++; if (vc.size() < 300) begin bad++; $display("FAIL fs_count: got %0d want >=300", vc.size()); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL fs_settled: got %0d bad samples want 0", nerr); end
        if (vc.size() > 0) begin
            total++; if (vi[vc.size()-1] !== -32768) begin bad++; $display("FAIL fs_last_i: got %0d want -32768", vi[vc.size()-1]); end
            total++; if (vq[vc.size()-1] !== 32767) begin bad++; $display("FAIL fs_last_q: got %0d want 32767", vq[vc.size()-1]); end
        end
    endtask

    task automatic test_impulse;
        int exp_i[8] = '{0, 0, 1024, 6144, 1024, 0, 0, 0};
        in_i = '0;
        in_q = '0;
        do_reset(3'd1);
        @(negedge clk);
        in_i = 16'sd16384;
        @(negedge clk);
        in_i = '0;
        run(30);
        total++; if (vc.size() < 8) begin bad++; $display("FAIL imp_count: got %0d want >=8", vc.size()); end
        for (int k = 0; k < 8 && k < vc.size(); k++) begin
            total++; if (vc[k] !== rel + 7 + 2 * k) begin bad++; $display("FAIL imp_time[%0d]: got %0d want %0d", k, vc[k] - rel, 7 + 2 * k); end
            total++; if (vi[k] !== exp_i[k]) begin bad++; $display("FAIL imp_i[%0d]: got %0d want %0d", k, vi[k], exp_i[k]); end
            total++; if (vq[k] !== 0) begin bad++; $display("FAIL imp_q[%0d]: got %0d want 0", k, vq[k]); end
        end
    endtask

    task automatic test_rate_change;
        int exp_c[8] = '{13, 21, 29, 61, 93, 125, 157, 189};
        in_i = 16'sd500;
        in_q = 16'sd500;
        do_reset(3'd3);
        while (cyc < rel + 20) @(negedge clk);
        dec_log2 = 3'd5;
        while (cyc < rel + 195) @(negedge clk);
        total++; if (vc.size() != 8) begin bad++; $display("FAIL rc_count: got %0d want 8", vc.size()); end
        for (int k = 0; k < 8 && k < vc.size(); k++) begin
            total++; if (vc[k] !== rel + exp_c[k]) begin bad++; $display("FAIL rc_time[%0d]: got %0d want %0d", k, vc[k] - rel, exp_c[k]); end
        end
        for (int k = 6; k < 8 && k < vc.size(); k++) begin
            total++; if (vi[k] !== 500) begin bad++; $display("FAIL rc_i[%0d]: got %0d want 500", k, vi[k]); end
            total++; if (vq[k] !== 500) begin bad++; $display("FAIL rc_q[%0d]: got %0d want 500", k, vq[k]); end
        end
    endtask

    task automatic test_clamp;
        in_i = '0;
        in_q = '0;
        do_reset(3'd0);
        run(12);
        total++; if (vc.size() != 3) begin bad++; $display("FAIL clamp0_count: got %0d want 3", vc.size()); end
        for (int k = 0; k < 3 && k < vc.size(); k++) begin
            total++; if (vc[k] !== rel + 7 + 2 * k) begin bad++; $display("FAIL clamp0_time[%0d]: got %0d want %0d", k, vc[k] - rel, 7 + 2 * k); end
        end
        do_reset(3'd7);
        run(140);
        total++; if (vc.size() != 2) begin bad++; $display("FAIL clamp7_count: got %0d want 2", vc.size()); end
        for (int k = 0; k < 2 && k < vc.size(); k++) begin
            total++; if (vc[k] !== rel + 69 + 64 * k) begin bad++; $display("FAIL clamp7_time[%0d]: got %0d want %0d", k, vc[k] - rel, 69 + 64 * k); end
        end
    endtask

    task automatic test_reset_mid;
        in_i = 16'sd1000;
        in_q = -16'sd1000;
        do_reset(3'd3);
        while (cyc < rel + 26) @(negedge clk);
        do_reset(3'd3);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", out_valid); end
        total++; if (out_i !== 16'sd0) begin bad++; $display("FAIL mid_out_i: got %0d want 0", out_i); end
        total++; if (out_q !== 16'sd0) begin bad++; $display("FAIL mid_out_q: got %0d want 0", out_q); end
        run(24);
        total++; if (vc.size() != 2) begin bad++; $display("FAIL mid_count: got %0d want 2", vc.size()); end
        if (vc.size() > 0) begin
            total++; if (vc[0] !== rel + 13) begin bad++; $display("FAIL mid_first_time: got %0d want 13", vc[0] - rel); end
            total++; if (vi[0] !== 8) begin bad++; $display("FAIL mid_first_i: got %0d want 8", vi[0]); end
            total++; if (vq[0] !== -9) begin bad++; $display("FAIL mid_first_q: got %0d want -9", vq[0]); end
        end
        if (vc.size() > 1) begin
            total++; if (vc[1] !== rel + 21) begin bad++; $display("FAIL mid_second_time: got %0d want 21", vc[1] - rel); end
        end
    endtask

    initial begin
        test_reset;
        test_dc;
        test_impulse;
        test_rate_change;
        test_clamp;
        test_reset_mid;
        test_fullscale;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
